qcw_multi_driver_control: RTL
=============================

Name: qcw_multi_driver_control

Overview:
- Memory-mapped control block for N independent QCW bridge drivers on the CPU native bus (valid/ready/addr/wdata/wstrb/rdata).
- Per channel: cycle-limit register, start/halt command pulses, a run-tracking FSM that follows the driver's ready handshake, sticky status, a run counter and an interrupt source.
- Sits between the CPU bus fabric and the per-bridge QCW drivers; a global halt-all covers emergency stop.

Parameters:
- BASE_ADDR, 32'h00000000, byte base address of the register window
- NUM_CHANNELS, 2, number of driver channels (1..8)
- LIMIT_WIDTH, 16, width of each cycle-limit register (1..32)
- DEFAULT_LIMIT, 16'd0, reset value of every cycle-limit register
- ACK_TIMEOUT, 255, cycles allowed for a driver to drop ready after a start pulse

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mem_valid_i  in  1  bus request valid
- mem_ready_o  out  1  one-cycle transaction acknowledge
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  write data
- mem_wstrb_i  in  4  byte write strobes; all-zero means read
- mem_rdata_o  out  32  read data, valid while mem_ready_o is high
- qcw_start  out  NUM_CHANNELS  per-channel one-cycle start pulse
- qcw_halt  out  NUM_CHANNELS  per-channel one-cycle halt pulse
- qcw_cycle_limit  out  NUM_CHANNELS*LIMIT_WIDTH  flattened limits; channel n occupies [n*LIMIT_WIDTH +: LIMIT_WIDTH]
- ready  in  NUM_CHANNELS  driver idle/ready, one bit per channel
- irq  out  1  level interrupt: OR over channels of (done | fault) & irq_en

Behaviour:
- Address window: BASE_ADDR up to BASE_ADDR + 0x10*(NUM_CHANNELS+1) - 1. Bits [1:0] are ignored.
- Global registers:
  - +0x00 GCTRL: a write with bit0=1 halts all channels; reads return {24'b0, NUM_CHANNELS[7:0]}.
  - +0x04 IRQ_EN: NUM_CHANNELS bits, read/write.
  - +0x08 DONE_SUMMARY: read-only, done bits of all channels.
- Channel n registers, at BASE_ADDR + 0x10 + 0x10*n:
  - +0x0 CTRL: write bit0=start, bit1=halt, bit2=clear status. Reads as 0.
  - +0x4 LIMIT: read/write. Byte strobes are honoured per byte; only bits below LIMIT_WIDTH are stored. Read is zero-extended.
  - +0x8 STATUS: read-only {27'b0, fault, rejected, done, busy, ready}.
  - +0xC RUN_COUNT: 16-bit, read-only.
- Unmapped offsets inside the window: reads return 0, writes are ignored.
- Bus handshake:
  - On the first cycle the window is addressed with mem_valid_i high, the block registers the access. On the next clock mem_ready_o=1 for exactly one cycle, with mem_rdata_o valid.
  - No second ack is issued until mem_valid_i drops or the address leaves the window; edge detect on addressed.
  - mem_rdata_o is 0 whenever mem_ready_o is 0.
  - Writes take effect on the ack edge.
- Channel FSM, states IDLE, ACK_WAIT, RUN, HALT_WAIT:
  - IDLE:
    - Start with ready=1: pulse qcw_start[n] for one cycle, load the ack timer with ACK_TIMEOUT, go to ACK_WAIT.
    - Start with ready=0: set rejected, no pulse.
  - ACK_WAIT:
    - ready=0: go to RUN.
    - Timer reaches 0: set fault, pulse qcw_halt[n], go to HALT_WAIT.
  - RUN:
    - ready=1: set done, RUN_COUNT+1 (wraps 0xFFFF to 0), go to IDLE.
  - HALT_WAIT:
    - ready=1: go to IDLE. No done, no count.
  - busy = (state != IDLE).
- Halt (channel CTRL bit1 or GCTRL bit0) in any state: pulse qcw_halt for one cycle. From ACK_WAIT or RUN, go to HALT_WAIT. From IDLE, stay in IDLE.
- Conflicts:
  - Start and halt in the same write: halt wins, no start pulse.
  - Start while busy: set rejected, state unchanged.
  - Clear status (bit2) and a hardware set of the same flag on the same cycle: set wins.
- Writing LIMIT while busy updates the output immediately; the driver is responsible for sampling it at start.
- Reset asserted (including mid-run): all FSMs go to IDLE; qcw_start, qcw_halt, mem_ready_o, mem_rdata_o, irq = 0; LIMIT = DEFAULT_LIMIT; IRQ_EN, status flags and RUN_COUNT = 0. No halt pulse is generated on reset.

Decomposition:
- Shared package qcw_pkg: register offset constants, CTRL/STATUS bit indices, FSM state encoding.
- Natural sub-module qcw_channel_fsm. One instance per channel via generate. It owns the FSM, ack timer, sticky flags and RUN_COUNT. Inputs are decoded start/halt/clear strobes and ready.
- The top level holds bus decode, global registers and read mux.

Test Plan:
- Write LIMIT ch1 = 0x1234 with wstrb=4'b0001 after reset -> qcw_cycle_limit ch1 = 0x0034. Readback 0x00000034. mem_ready_o high for exactly 1 cycle per access.
- ch0 ready=1, write CTRL=1 -> qcw_start[0] is a single-cycle pulse. Drop ready after 5 cycles, raise after 100 -> STATUS=0b00101, RUN_COUNT=1. With IRQ_EN=1, irq=1; CTRL=4 clears it.
- Start ch0 with ready held at 1 and ACK_TIMEOUT=255 -> fault after 255 cycles, qcw_halt[0] pulse, STATUS fault=1, busy until ready, RUN_COUNT unchanged.
- Start ch0 while RUN, and start ch1 while its ready=0 -> rejected=1 on both, no extra qcw_start pulses. Write CTRL=3 -> only a halt pulse.
- Two channels running, GCTRL=1 -> qcw_halt=2'b11 for one cycle. Both end in IDLE on ready rise with done=0.
- Assert reset mid-RUN with RUN_COUNT=0xFFFF -> all outputs 0, count 0. Separately, one completion at 0xFFFF wraps to 0x0000.

Source files
------------

// File: rtl/qcw_pkg.sv
// Shared definitions for the QCW multi-driver controller: register map,
// CTRL bit positions, channel FSM encoding and the status word layout.
package qcw_pkg;

    // Global page (offset 0x00..0x0F)
    localparam logic [3:0] REG_GCTRL     = 4'h0;
    localparam logic [3:0] REG_IRQ_EN    = 4'h4;
    localparam logic [3:0] REG_DONE_SUM  = 4'h8;

    // Per-channel page
    localparam logic [3:0] REG_CTRL      = 4'h0;
    localparam logic [3:0] REG_LIMIT     = 4'h4;
    localparam logic [3:0] REG_STATUS    = 4'h8;
    localparam logic [3:0] REG_RUN_COUNT = 4'hC;

    localparam int CTRL_START = 0;
    localparam int CTRL_HALT  = 1;
    localparam int CTRL_CLEAR = 2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ACK_WAIT  = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_HALT_WAIT = 2'd3;

    // Packed so that it reads back directly as STATUS[4:0]
    typedef struct packed {
        logic fault;
        logic rejected;
        logic done;
        logic busy;
        logic ready;
    } status_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/qcw_channel_fsm.sv
// Run tracker for one QCW bridge driver: start/halt pulses, ack timeout,
// sticky status flags and a wrapping completion counter.
//
// state     | meaning
// IDLE      | driver idle, waiting for a start command
// ACK_WAIT  | start pulsed, waiting for driver to drop ready (timed)
// RUN       | driver running, waiting for ready to return
// HALT_WAIT | halt pulsed, waiting for driver to return to ready
module qcw_channel_fsm
    import qcw_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        clear_i,
    input  logic        ready_i,
    output logic        start_o,
    output logic        halt_o,
    output status_t     status_o,
    output logic [15:0] run_count_o
);

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          start_q, start_d, halt_q, halt_d;
    logic          done_q, done_d, rej_q, rej_d, fault_q, fault_d;
    logic [15:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start_d = 1'b0;
        halt_d  = 1'b0;
        done_d  = done_q;
        rej_d   = rej_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        // Clear first so that a hardware set later in this block wins
        if (clear_i) begin
            done_d  = 1'b0;
            rej_d   = 1'b0;
            fault_d = 1'b0;
        end
        if (halt_i) begin
            halt_d = 1'b1;
            if (state_q == S_ACK_WAIT || state_q == S_RUN)
                state_d = S_HALT_WAIT;
        end else begin
            if (start_i && state_q != S_IDLE)
                rej_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (ready_i) begin
                            start_d = 1'b1;
                            timer_d = TW'(ACK_TIMEOUT);
                            state_d = S_ACK_WAIT;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                S_ACK_WAIT: begin
                    if (!ready_i) begin
                        state_d = S_RUN;
                    end else if (timer_q <= TW'(1)) begin
                        fault_d = 1'b1;
                        halt_d  = 1'b1;
                        state_d = S_HALT_WAIT;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_RUN: begin
                    if (ready_i) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    if (ready_i)
                        state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            start_q <= 1'b0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            start_q <= start_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign start_o     = start_q;
    assign halt_o      = halt_q;
    assign run_count_o = cnt_q;
    assign status_o    = '{fault: fault_q, rejected: rej_q, done: done_q,
                           busy: (state_q != S_IDLE), ready: ready_i};

endmodule

// File: rtl/qcw_multi_driver_control.sv
// Memory-mapped control for NUM_CHANNELS QCW bridge drivers: bus decode with
// one-cycle ack, global registers, per-channel limits and read mux.
module qcw_multi_driver_control
    import qcw_pkg::*;
#(
    parameter logic [31:0]            BASE_ADDR     = 32'h0000_0000,
    parameter int                     NUM_CHANNELS  = 2,
    parameter int                     LIMIT_WIDTH   = 16,
    parameter logic [LIMIT_WIDTH-1:0] DEFAULT_LIMIT = '0,
    parameter int                     ACK_TIMEOUT   = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                mem_valid_i,
    output logic                                mem_ready_o,
    input  logic [31:0]                         mem_addr_i,
    input  logic [31:0]                         mem_wdata_i,
    input  logic [3:0]                          mem_wstrb_i,
    output logic [31:0]                         mem_rdata_o,
    output logic [NUM_CHANNELS-1:0]             qcw_start,
    output logic [NUM_CHANNELS-1:0]             qcw_halt,
    output logic [NUM_CHANNELS*LIMIT_WIDTH-1:0] qcw_cycle_limit,
    input  logic [NUM_CHANNELS-1:0]             ready,
    output logic                                irq
);

    localparam logic [31:0] WIN_BYTES = 32'(16 * (NUM_CHANNELS + 1));

    logic [31:0]             offset;
    logic [3:0]              page, reg_ofs;
    logic                    addressed, addressed_q, new_access, wr_en;
    logic                    ack_q;
    logic [31:0]             rdata_q, rd_data;
    logic [NUM_CHANNELS-1:0] irq_en_q;
    logic [LIMIT_WIDTH-1:0]  limit_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_start, ch_halt, ch_clear, limit_we;
    logic [NUM_CHANNELS-1:0] done_vec, irq_src;
    logic                    glb_sel, halt_all, irq_en_we;
    status_t                 status [NUM_CHANNELS];
    logic [15:0]             run_count [NUM_CHANNELS];
    logic                    unused_addr_bits;

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window
    assign offset           = mem_addr_i - BASE_ADDR;
    assign page             = offset[7:4];
    assign reg_ofs          = {offset[3:2], 2'b00};
    assign unused_addr_bits = ^offset[1:0];
    assign addressed        = mem_valid_i && (offset < WIN_BYTES);
    assign new_access       = addressed && !addressed_q;
    assign wr_en            = new_access && (mem_wstrb_i != 4'b0000);
    assign glb_sel          = (page == 4'd0);
    assign halt_all         = wr_en && glb_sel && (reg_ofs == REG_GCTRL) && mem_wdata_i[0];
    assign irq_en_we        = wr_en && glb_sel && (reg_ofs == REG_IRQ_EN);

    always_comb begin
        ch_start = '0;
        ch_halt  = '0;
        ch_clear = '0;
        limit_we = '0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (wr_en && page == 4'(n + 1)) begin
                if (reg_ofs == REG_CTRL) begin
                    ch_start[n] = mem_wdata_i[CTRL_START];
                    ch_halt[n]  = mem_wdata_i[CTRL_HALT];
                    ch_clear[n] = mem_wdata_i[CTRL_CLEAR];
                end
                limit_we[n] = (reg_ofs == REG_LIMIT);
            end
            ch_halt[n] = ch_halt[n] | halt_all;
        end
    end

    always_comb begin
        rd_data = '0;
        if (glb_sel) begin
            case (reg_ofs)
                REG_GCTRL:    rd_data = {24'b0, 8'(NUM_CHANNELS)};
                REG_IRQ_EN:   rd_data = 32'(irq_en_q);
                REG_DONE_SUM: rd_data = 32'(done_vec);
                default:      rd_data = '0;
            endcase
        end
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (page == 4'(n + 1)) begin
                case (reg_ofs)
                    REG_LIMIT:     rd_data = 32'(limit_q[n]);
                    REG_STATUS:    rd_data = 32'(status[n]);
                    REG_RUN_COUNT: rd_data = 32'(run_count[n]);
                    default:       rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addressed_q <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            irq_en_q    <= '0;
            for (int n = 0; n < NUM_CHANNELS; n++)
                limit_q[n] <= DEFAULT_LIMIT;
        end else begin
            addressed_q <= addressed;
            ack_q       <= new_access;
            rdata_q     <= (new_access && !wr_en) ? rd_data : '0;
            if (irq_en_we)
                irq_en_q <= NUM_CHANNELS'(merge_bytes(32'(irq_en_q), mem_wdata_i, mem_wstrb_i));
            for (int n = 0; n < NUM_CHANNELS; n++)
                if (limit_we[n])
                    limit_q[n] <= LIMIT_WIDTH'(merge_bytes(32'(limit_q[n]), mem_wdata_i, mem_wstrb_i));
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        qcw_channel_fsm #(
            .ACK_TIMEOUT(ACK_TIMEOUT)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .start_i    (ch_start[g]),
            .halt_i     (ch_halt[g]),
            .clear_i    (ch_clear[g]),
            .ready_i    (ready[g]),
            .start_o    (qcw_start[g]),
            .halt_o     (qcw_halt[g]),
            .status_o   (status[g]),
            .run_count_o(run_count[g])
        );
        assign qcw_cycle_limit[g*LIMIT_WIDTH +: LIMIT_WIDTH] = limit_q[g];
        assign done_vec[g] = status[g].done;
        assign irq_src[g]  = status[g].done | status[g].fault;
    end

    assign mem_ready_o = ack_q;
    assign mem_rdata_o = rdata_q;
    assign irq         = |(irq_src & irq_en_q);

endmodule
